// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scanner.
// Segment patterns are 7-bit GFEDCBA, active-low (0 = segment lit).
// clog2 sizes the prescaler and scan-index counters.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] DP_ONLY = 8'h7F;

  // Smallest r with 2**r >= v.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to 7-segment decoder (full hex, 0..F).
// Ports:
//   nib  in  4  hex value
//   seg  out 7  GFEDCBA pattern, active-low
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner.
// Each digit slot lasts P_PRESCALE clocks; the first P_BLANK clocks of a slot
// keep every anode off to stop ghosting between digits. The displayed value is
// a snapshot taken at the end of each frame, so a frame never mixes old and
// new digits. Leading zeros can be blanked; a blanked digit with its DP
// requested still lights the DP alone.
// Optional macro SEG_DIM_EN adds input bright[3:0]: during the active phase
// the anode is on only while pre[3:0] <= bright (needs P_PRESCALE >= 16).
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous reset, active-low
//   digits      in   4*P_DIGITS, nibble k = digit k, digit 0 rightmost
//   dp          in   P_DIGITS decimal-point requests, 1 = lit
//   lzb_en      in   1 = blank leading zeros (not snapshotted)
//   bright      in   4-bit brightness (SEG_DIM_EN only)
//   ano         out  P_DIGITS anodes, active-low, registered
//   cat         out  {DP,G,F,E,D,C,B,A}, active-low, registered
//   frame_tick  out  one-cycle pulse when slot 0 begins
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int P_DIGITS   = 4,
  parameter int P_PRESCALE = 2048,
  parameter int P_BLANK    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*P_DIGITS-1:0] digits,
  input  logic [P_DIGITS-1:0]   dp,
  input  logic                  lzb_en,
`ifdef SEG_DIM_EN
  input  logic [3:0]            bright,
`endif
  output logic [P_DIGITS-1:0]   ano,
  output logic [7:0]            cat,
  output logic                  frame_tick
);

  localparam int PW = clog2(P_PRESCALE);
  localparam int IW = (P_DIGITS > 1) ? clog2(P_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(P_PRESCALE - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(P_DIGITS - 1);

  logic [PW-1:0]         pre;
  logic [IW-1:0]         idx;
  logic [4*P_DIGITS-1:0] snap;
  logic [P_DIGITS-1:0]   snap_dp;

  logic wrap, frame_end;
  assign wrap      = (pre == PRE_MAX);
  assign frame_end = wrap && (idx == IDX_MAX);

  // Prescaler, scan index, frame snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre        <= '0;
      idx        <= '0;
      snap       <= '0;
      snap_dp    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (wrap) begin
        pre <= '0;
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (frame_end) begin
        snap    <= digits;
        snap_dp <= dp;
      end
    end
  end

  logic [3:0] cur_nib;
  logic [6:0] cur_seg;
  logic       cur_dp;
  assign cur_nib = snap[idx*4 +: 4];
  assign cur_dp  = snap_dp[idx];

  hex_to_seg u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

  // zero_from[k] = nibbles k..P_DIGITS-1 of the snapshot are all zero.
  logic [P_DIGITS:0] zero_from;
  always_comb begin
    zero_from = '0;
    zero_from[P_DIGITS] = 1'b1;
    for (int k = P_DIGITS - 1; k >= 0; k--)
      zero_from[k] = (snap[k*4 +: 4] == 4'h0) && zero_from[k+1];
  end

  logic lz_blank;
  assign lz_blank = lzb_en && (idx != '0) && zero_from[idx];

  logic blank_ph;
  generate
    if (P_BLANK == 0) begin : g_noblank
      assign blank_ph = 1'b0;
    end else begin : g_blank
      assign blank_ph = (pre < PW'(P_BLANK));
    end
  endgenerate

  logic dim_on;
`ifdef SEG_DIM_EN
  assign dim_on = (pre[3:0] <= bright);
`else
  assign dim_on = 1'b1;
`endif

  logic [P_DIGITS-1:0] ano_d;
  logic [7:0]          cat_d;
  always_comb begin
    ano_d = '1;
    cat_d = 8'hFF;
    if (!blank_ph && dim_on) begin
      if (lz_blank) begin
        // Blanked digit keeps anode off unless its DP must be shown.
        if (cur_dp) begin
          ano_d[idx] = 1'b0;
          cat_d      = DP_ONLY;
        end
      end else begin
        ano_d[idx] = 1'b0;
        cat_d      = {~cur_dp, cur_seg};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ano <= '1;
      cat <= 8'hFF;
    end else begin
      ano <= ano_d;
      cat <= cat_d;
    end
  end

endmodule
